clock_seq_ctrl: RTL and testbench
=================================

Name: clock_seq_ctrl

Overview:
Sequencing controller for the digital-clock datapath. It drives three 2-digit BCD/7-segment counters (seconds, minutes, hours) by issuing one-cycle enable pulses. It owns the 1 Hz prescaler, the run/set mode FSM, manual increment from user buttons, and field-blink control for the display stage. It sits between the debounced button inputs and the counter instances.

Parameters:
TICK_DIV, 50000000, clk cycles per second; must be ≥ 4.
BLINK_HALF, 25000000, clk cycles per blink half-period in set modes; must be ≥ 1.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
btn_mode  input  1  debounced mode button, level, synchronous to clk
btn_inc  input  1  debounced increment button, level, synchronous to clk
sec_wrap  input  1  seconds counter currently at 59 (combinational from counter)
min_wrap  input  1  minutes counter currently at 59
en_sec  output  1  one-cycle count enable, seconds counter
en_min  output  1  one-cycle count enable, minutes counter
en_hour  output  1  one-cycle count enable, hours counter
clr_sec  output  1  one-cycle synchronous clear, seconds counter
mode  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN
blank_hour  output  1  blank hour digits (blink phase)
blank_min  output  1  blank minute digits (blink phase)
tick_1hz  output  1  prescaler terminal pulse, observation only

Behaviour:
- Reset (rst=1 at a clk edge): state RUN, prescaler 0, blink counter 0, blink phase 0, all outputs 0. Button-history registers reset to 1, so a button held through reset gives no edge until it is released and pressed again.
- Edge detect: press = btn & ~btn_q, where btn_q is the previous-cycle value. Press is combinational from the current input and the registered history.
- Prescaler: counts 0..TICK_DIV-1 in RUN only. tick_1hz=1 for the single cycle where count==TICK_DIV-1, then it wraps to 0. Held at 0 in both set states.
- FSM transitions on mode press: RUN→SET_HOUR→SET_MIN→RUN. Code 11 is unreachable; if entered, return to RUN next cycle.
- RUN state, all combinational from registered state:
  - en_sec = tick
  - en_min = tick & sec_wrap
  - en_hour = tick & sec_wrap & min_wrap
- SET_HOUR: en_hour = inc press; en_sec = en_min = 0; no cascade (hour counter self-wraps 23→00).
- SET_MIN: en_min = inc press; en_sec = en_hour = 0; no carry into hours on 59→00.
- Leaving SET_MIN→RUN:
  - clr_sec=1 in the same cycle as the mode press.
  - Prescaler restarts at 0, so the first en_sec comes TICK_DIV cycles after entering RUN.
- Mode press and inc press in the same cycle: mode wins, increment discarded.
- Blink in set states:
  - Counter runs 0..BLINK_HALF-1; blink phase toggles at the terminal count.
  - blank_hour = (state==SET_HOUR) & phase; blank_min = (state==SET_MIN) & phase.
  - Counter and phase clear to 0 on every state change, so the selected field shows immediately.
  - Both blank outputs are 0 in RUN.
- rst mid-operation (any state): next cycle matches the reset values. Counter contents are not touched by this block.

Optional Feature:
Macro AUTO_REPEAT_EN.
- Defined: in a set state, btn_inc held continuously for TICK_DIV cycles after the press produces a further increment pulse. It then repeats every TICK_DIV/4 cycles while held. The repeat counter clears on release or state change.
- Undefined: exactly one increment per press; no repeat counter synthesised.

Decomposition:
- Package clock_ctrl_pkg holds:
  - mode encodings ST_RUN=2'b00, ST_SET_HOUR=2'b01, ST_SET_MIN=2'b10
  - a function computing the prescaler counter width from TICK_DIV
- Sub-module btn_edge: history register with reset-to-1 and a press output, instantiated for btn_mode and btn_inc.

Test Plan (TICK_DIV=10, BLINK_HALF=4):
- Reset, hold RUN 35 cycles, sec_wrap=0 → en_sec pulses at cycles 10, 20, 30 (counting from reset release); en_min and en_hour stay 0; mode=00.
- RUN with sec_wrap=1, min_wrap=1 at a tick → en_sec, en_min and en_hour all 1 in that one cycle.
- Press mode once, then inc 3 times → mode=01, 3 en_hour pulses, 0 en_min pulses. blank_hour is 0 for 4 cycles, then 1 for 4 cycles, and so on.
- Press mode to SET_MIN, inc twice, press mode → 2 en_min pulses, no en_hour carry. clr_sec=1 with the mode press, mode=00, and the next en_sec is exactly 10 cycles later.
- Mode and inc pressed in the same cycle in SET_HOUR → mode=10, no en_hour pulse. Holding btn_mode through rst and then releasing → no transition.
- rst asserted in SET_MIN mid-blink → next cycle mode=00, blank_min=0, all enables 0. With AUTO_REPEAT_EN, inc held 20 cycles in SET_HOUR → pulses at press, +10 and +12 (TICK_DIV/4 integer-truncated to 2), +14, …

Source files
------------

// File: rtl/clock_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_ctrl_pkg
// Purpose  : Shared mode encodings and counter-width helper for the
//            digital-clock sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10,
        ST_ILLEGAL  = 2'b11
    } state_e;

    // Bits needed for a counter spanning 0..n-1 (never narrower than 1).
    function automatic int cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : clock_ctrl_pkg
`default_nettype wire

// File: rtl/clock_seq_ctrl_btn_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_edge
// Purpose  : Rising-edge press detector for a debounced, clk-synchronous
//            button level. History resets to 1 so a held button needs a
//            release before it can register a press.
// Revision : 1.0 - initial release
// ============================================================================
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    logic hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= btn_i;
        end
    end

    assign press_o = btn_i & ~hist_q;

endmodule : btn_edge
`default_nettype wire

// File: rtl/clock_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_seq_ctrl
// Purpose  : 1 Hz prescaler, RUN/SET mode FSM, manual increment and blink
//            control driving the seconds/minutes/hours counters.
//            Optional macro AUTO_REPEAT_EN: held increment button repeats.
// Revision : 1.0 - initial release
// ============================================================================
module clock_seq_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int BLINK_HALF = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_wrap,
    input  logic       min_wrap,
    output logic       en_sec,
    output logic       en_min,
    output logic       en_hour,
    output logic       clr_sec,
    output logic [1:0] mode,
    output logic       blank_hour,
    output logic       blank_min,
    output logic       tick_1hz
);

    localparam int c_PRE_W = cnt_width(TICK_DIV);
    localparam int c_BLK_W = cnt_width(BLINK_HALF);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);
    localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(BLINK_HALF - 1);

    state_e             state_q, state_d;
    logic [c_PRE_W-1:0] pre_q, pre_d;
    logic [c_BLK_W-1:0] blk_q, blk_d;
    logic               phase_q, phase_d;

    logic w_mode_press;
    logic w_inc_press;
    logic w_inc_pulse;
    logic w_tick;
    logic w_in_set;
    logic w_state_chg;

    btn_edge u_btn_mode (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_mode),
        .press_o (w_mode_press)
    );

    btn_edge u_btn_inc (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_inc),
        .press_o (w_inc_press)
    );

    assign w_tick      = (state_q == ST_RUN) && (pre_q == c_PRE_LAST);
    assign w_in_set    = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);
    assign w_state_chg = (state_d != state_q);

`ifdef AUTO_REPEAT_EN
    localparam int c_REP_W = cnt_width(TICK_DIV + 1);
    localparam logic [c_REP_W-1:0] c_REP_FIRST = c_REP_W'(TICK_DIV);
    localparam logic [c_REP_W-1:0] c_REP_NEXT  = c_REP_W'(TICK_DIV / 4);

    logic               rep_act_q, rep_act_d;
    logic               rep_first_q, rep_first_d;
    logic [c_REP_W-1:0] rep_q, rep_d;
    logic               w_rep_fire;

    // rep_q counts cycles since the press (or since the last repeat).
    assign w_rep_fire  = rep_act_q &&
                         (rep_q == (rep_first_q ? c_REP_FIRST : c_REP_NEXT));
    assign w_inc_pulse = w_inc_press | w_rep_fire;

    always_comb begin
        rep_act_d   = 1'b0;
        rep_first_d = 1'b1;
        rep_d       = '0;
        if (w_in_set && btn_inc && !w_state_chg) begin
            if (w_inc_press) begin
                rep_act_d = 1'b1;
                rep_d     = c_REP_W'(1);
            end else if (rep_act_q) begin
                rep_act_d   = 1'b1;
                rep_first_d = rep_first_q & ~w_rep_fire;
                rep_d       = w_rep_fire ? c_REP_W'(1) : rep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_act_q   <= 1'b0;
            rep_first_q <= 1'b1;
            rep_q       <= '0;
        end else begin
            rep_act_q   <= rep_act_d;
            rep_first_q <= rep_first_d;
            rep_q       <= rep_d;
        end
    end
`else
    assign w_inc_pulse = w_inc_press;
`endif

    // Mode press always has priority; a coincident increment is dropped.
    always_comb begin
        state_d = state_q;
        en_sec  = 1'b0;
        en_min  = 1'b0;
        en_hour = 1'b0;
        clr_sec = 1'b0;
        case (state_q)
            ST_RUN: begin
                en_sec  = w_tick;
                en_min  = w_tick & sec_wrap;
                en_hour = w_tick & sec_wrap & min_wrap;
                if (w_mode_press) begin
                    state_d = ST_SET_HOUR;
                end
            end
            ST_SET_HOUR: begin
                en_hour = w_inc_pulse & ~w_mode_press;
                if (w_mode_press) begin
                    state_d = ST_SET_MIN;
                end
            end
            ST_SET_MIN: begin
                en_min = w_inc_pulse & ~w_mode_press;
                if (w_mode_press) begin
                    state_d = ST_RUN;
                    clr_sec = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Prescaler and blink timers restart on every state change.
    always_comb begin
        pre_d   = '0;
        blk_d   = '0;
        phase_d = 1'b0;
        if ((state_q == ST_RUN) && !w_state_chg) begin
            pre_d = w_tick ? '0 : pre_q + 1'b1;
        end
        if (w_in_set && !w_state_chg) begin
            if (blk_q == c_BLK_LAST) begin
                blk_d   = '0;
                phase_d = ~phase_q;
            end else begin
                blk_d   = blk_q + 1'b1;
                phase_d = phase_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pre_q   <= '0;
            blk_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            blk_q   <= blk_d;
            phase_q <= phase_d;
        end
    end

    assign mode       = state_q;
    assign tick_1hz   = w_tick;
    assign blank_hour = (state_q == ST_SET_HOUR) & phase_q;
    assign blank_min  = (state_q == ST_SET_MIN) & phase_q;

endmodule : clock_seq_ctrl
`default_nettype wire

// File: tb/tb_clock_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_seq_ctrl
// Purpose  : Scoreboard bench for clock_seq_ctrl (TICK_DIV=10, BLINK_HALF=4)
//            with a time-based reference model; honours AUTO_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_seq_ctrl;

    localparam int TD = 10;
    localparam int BH = 4;

    logic       clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_inc;
    logic       sec_wrap;
    logic       min_wrap;
    logic       en_sec;
    logic       en_min;
    logic       en_hour;
    logic       clr_sec;
    logic [1:0] mode;
    logic       blank_hour;
    logic       blank_min;
    logic       tick_1hz;

    clock_seq_ctrl #(
        .TICK_DIV   (TD),
        .BLINK_HALF (BH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .sec_wrap   (sec_wrap),
        .min_wrap   (min_wrap),
        .en_sec     (en_sec),
        .en_min     (en_min),
        .en_hour    (en_hour),
        .clr_sec    (clr_sec),
        .mode       (mode),
        .blank_hour (blank_hour),
        .blank_min  (blank_min),
        .tick_1hz   (tick_1hz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         cyc;
        logic [8:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_n    = 0;

    // Reference model: mode 0 RUN, 1 SET_HOUR, 2 SET_MIN; times since entry.
    int   m_mode;
    int   m_run;
    int   m_set;
    int   m_hold;
    logic m_pbm;
    logic m_pbi;

    task automatic model_reset();
        m_mode = 0;
        m_run  = 0;
        m_set  = 0;
        m_hold = -1;
        m_pbm  = 1'b1;
        m_pbi  = 1'b1;
    endtask

    task automatic model_step(input logic r, input logic bm, input logic bi,
                              input logic sw, input logic mw);
        logic mp, ip, tick, fire, inc;
        logic es, em, eh, cs, bhr, bmn;
        int   nm;
        exp_t e;
        mp   = bm & ~m_pbm;
        ip   = bi & ~m_pbi;
        tick = (m_mode == 0) && ((m_run % TD) == TD - 1);
`ifdef AUTO_REPEAT_EN
        fire = (m_mode != 0) && (m_hold >= TD) && (((m_hold - TD) % (TD / 4)) == 0);
`else
        fire = 1'b0;
`endif
        inc = (ip | fire) & ~mp;
        es  = (m_mode == 0) & tick;
        em  = ((m_mode == 0) & tick & sw) | ((m_mode == 2) & inc);
        eh  = ((m_mode == 0) & tick & sw & mw) | ((m_mode == 1) & inc);
        cs  = (m_mode == 2) & mp;
        bhr = (m_mode == 1) && (((m_set / BH) % 2) == 1);
        bmn = (m_mode == 2) && (((m_set / BH) % 2) == 1);
        e.cyc = cyc_n;
        e.v   = {2'(m_mode), es, em, eh, cs, bhr, bmn, tick};
        exp_q.push_back(e);

        nm = mp ? (m_mode + 1) % 3 : m_mode;
        if (r) begin
            model_reset();
        end else begin
            if ((m_mode != 0) && bi && (nm == m_mode) && (ip || m_hold >= 0)) begin
                m_hold = ip ? 1 : m_hold + 1;
            end else begin
                m_hold = -1;
            end
            if (nm != m_mode) begin
                m_run = 0;
                m_set = 0;
            end else if (m_mode == 0) begin
                m_run = m_run + 1;
            end else begin
                m_set = m_set + 1;
            end
            m_mode = nm;
            m_pbm  = bm;
            m_pbi  = bi;
        end
    endtask

    task automatic cyc(input logic r, input logic bm, input logic bi,
                       input logic sw, input logic mw);
        @(posedge clk);
        #1;
        rst      = r;
        btn_mode = bm;
        btn_inc  = bi;
        sec_wrap = sw;
        min_wrap = mw;
        cyc_n    = cyc_n + 1;
        model_step(r, bm, bi, sw, mw);
    endtask

    // Monitor: outputs are presented every cycle; compare at the falling edge.
    always @(negedge clk) begin : mon
        exp_t       e;
        logic [8:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {mode, en_sec, en_min, en_hour, clr_sec, blank_hour, blank_min, tick_1hz};
            n_checks = n_checks + 1;
            if (act === e.v) begin
                n_pass = n_pass + 1;
            end else begin
                $display("FAIL outputs cycle %0d {mode,en_sec,en_min,en_hour,clr_sec,blank_hour,blank_min,tick}: actual=%b required=%b",
                         e.cyc, act, e.v);
            end
        end
    end

    initial begin
        logic bm, bi;
        rst = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        sec_wrap = 1'b0;
        min_wrap = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // RUN with no carries, then a tick with both wraps set.
        repeat (35) cyc(0, 0, 0, 0, 0);
        repeat (12) cyc(0, 0, 0, 1, 1);

        // SET_HOUR: three increments, then watch the blink.
        cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0);
        end
        repeat (10) cyc(0, 0, 0, 0, 0);

        // SET_MIN: two increments, leave with clr_sec, then wait for en_sec.
        cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 1, 1, 1); cyc(0, 0, 0, 1, 1);
        end
        cyc(0, 1, 0, 1, 1);
        repeat (14) cyc(0, 0, 0, 0, 0);

        // Coincident mode+inc in SET_HOUR, then back to RUN.
        cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0); cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);

        // Mode button held through reset must not register.
        cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);

        // Reset in SET_MIN mid-blink.
        cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);

        // Increment held 20 cycles in SET_HOUR.
        cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        repeat (20) cyc(0, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);

        // Randomised button activity, wraps and occasional reset.
        bm = 1'b0;
        bi = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) bm = ~bm;
            if ($urandom_range(0, 3) == 0) bi = ~bi;
            cyc(($urandom_range(0, 199) == 0), bm, bi,
                ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1);
        end
        cyc(0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks = n_checks + 1;
            $display("FAIL scoreboard drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_clock_seq_ctrl
`default_nettype wire
